// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response,
// branch redirect and the valid/ready instruction hand-off to the core.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  branch_valid,
    input  branch_target,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output branch_valid,
    output branch_target,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests,
// buffers responses with their PCs and squashes stale words on a branch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_ifq_wp;
  logic [AW-1:0] r_ifq_rp;
  logic [31:0]   r_ifq_pc [FIFO_DEPTH];
  logic [31:0]   r_word   [FIFO_DEPTH];
  logic [31:0]   r_pc     [FIFO_DEPTH];
  logic          r_req;
  logic          r_valid;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_pc;

  logic          w_br;
  logic          w_issue;
  logic          w_resp;
  logic          w_keep;
  logic          w_pop;
  logic [31:0]   w_tgt;
  logic [31:0]   w_resp_pc;
  logic [CW-1:0] w_outst_n;
  logic [CW-1:0] w_drop_n;
  logic [CW-1:0] w_count_n;
  logic [AW-1:0] w_wp_n;
  logic [AW-1:0] w_rp_n;
  logic [31:0]   w_fetch_pc_n;
  logic [31:0]   w_head_word;
  logic [31:0]   w_head_pc;
  logic          w_req_n;
  logic          w_unused;

  assign w_unused  = ^bus.branch_target[1:0];
  assign w_br      = bus.branch_valid;
  assign w_issue   = r_req & bus.imem_gnt;
  assign w_resp    = bus.imem_rvalid;
  assign w_resp_pc = r_ifq_pc[r_ifq_rp];
  assign w_keep    = w_resp & (r_drop == '0) & ~w_br;
  assign w_pop     = r_valid & bus.instr_ready;
  assign w_tgt     = {bus.branch_target[31:2], 2'b00};
  assign w_outst_n = r_outst + CW'(w_issue) - CW'(w_resp);

  // Next-state for fetch PC, squash count, FIFO occupancy and next head.
  always_comb begin
    w_fetch_pc_n = r_fetch_pc;
    w_drop_n     = r_drop;
    w_count_n    = r_count + CW'(w_keep) - CW'(w_pop);
    w_wp_n       = r_wp + AW'(w_keep);
    w_rp_n       = r_rp + AW'(w_pop);
    if (w_issue) begin
      w_fetch_pc_n = r_fetch_pc + 32'd4;
    end
    if (w_resp && r_drop != '0) begin
      w_drop_n = r_drop - CW'(1);
    end
    if (w_br) begin
      w_fetch_pc_n = w_tgt;
      w_drop_n     = w_outst_n;
      w_count_n    = '0;
      w_wp_n       = '0;
      w_rp_n       = '0;
    end
    w_head_word = r_word[w_rp_n];
    w_head_pc   = r_pc[w_rp_n];
    if (w_keep && w_rp_n == r_wp) begin
      w_head_word = bus.imem_rdata;
      w_head_pc   = w_resp_pc;
    end
    w_req_n = ({1'b0, w_outst_n} + {1'b0, w_count_n}) < DEPTH_C;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= PC0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_ifq_wp   <= '0;
      r_ifq_rp   <= '0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_n;
      r_outst    <= w_outst_n;
      r_drop     <= w_drop_n;
      r_count    <= w_count_n;
      r_wp       <= w_wp_n;
      r_rp       <= w_rp_n;
      r_ifq_wp   <= r_ifq_wp + AW'(w_issue);
      r_ifq_rp   <= r_ifq_rp + AW'(w_resp);
      r_req      <= w_req_n;
      r_valid    <= (w_count_n != '0);
      if (w_count_n != '0) begin
        r_instr    <= w_head_word;
        r_instr_pc <= w_head_pc;
      end
    end
  end

  // In-flight PC queue and prefetch storage; pointers gate validity.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_ifq_pc[r_ifq_wp] <= r_fetch_pc;
    end
    if (w_keep) begin
      r_word[r_wp] <= bus.imem_rdata;
      r_pc[r_wp]   <= w_resp_pc;
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = r_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
endmodule
